// File: rtl/td4_fetch.sv
// TD4 instruction-fetch front end.
// Program memory is filled after reset through a valid/ready byte-stream
// loader, then the block runs: op = mem[pc] is presented combinationally to
// the decoder, pc advances on step or is loaded from the decoder's jump
// target, and an unconditional jump to the current address halts the core.
module td4_fetch #(
    parameter int          DEPTH  = 16,
    parameter int          AW     = 4,
    parameter int          WIDTH  = 8,
    parameter logic [3:0]  JMP_OP = 4'b1111
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             wr_last,
    input  logic             step,
    input  logic             pc_load,
    input  logic [AW-1:0]    pc_in,
    output logic [WIDTH-1:0] op,
    output logic             op_valid,
    output logic [AW-1:0]    pc,
    output logic             halted,
    output logic [AW:0]      load_count
);

    typedef enum logic [0:0] {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    waddr_r;
    logic [AW-1:0]    pc_r;
    logic             halted_r;
    logic [AW:0]      load_count_r;

    logic [WIDTH-1:0] op_s;
    logic             wr_fire_s;
    logic             load_done_s;
    logic             run_step_s;
    logic             halt_hit_s;

    // Datapath decode: loader handshake, end of load, gated step and halt detection.
    always_comb begin
        op_s        = mem_r[pc_r];
        wr_fire_s   = 1'b0;
        load_done_s = 1'b0;
        run_step_s  = 1'b0;
        halt_hit_s  = 1'b0;
        if (state_r == ST_LOAD) begin
            wr_fire_s   = wr_valid;
            // The last slot ends the load even without wr_last.
            load_done_s = wr_valid && (wr_last || (waddr_r == AW'(DEPTH - 1)));
        end else begin
            run_step_s  = step && !halted_r;
            // Only an unconditional jump to the current address is a halt;
            // conditional jumps to self fall through to a normal pc load.
            halt_hit_s  = step && !halted_r && pc_load && (pc_in == pc_r) &&
                          (op_s[WIDTH-1:WIDTH-4] == JMP_OP);
        end
    end

    // Next-state logic: LOAD -> RUN on the final accepted word; RUN is left only by reset.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_LOAD: begin
                if (load_done_s) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_LOAD;
                end
            end
            ST_RUN:  state_nxt_s = ST_RUN;
            default: state_nxt_s = ST_LOAD;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state_r <= ST_LOAD;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Program memory: cleared by reset so unloaded words read as zero.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (wr_fire_s) begin
            mem_r[waddr_r] <= wr_data;
        end
    end

    // Loader write address and word counter (saturating at DEPTH).
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            waddr_r      <= '0;
            load_count_r <= '0;
        end else if (wr_fire_s) begin
            waddr_r <= waddr_r + AW'(1);
            if (load_count_r != (AW + 1)'(DEPTH)) begin
                load_count_r <= load_count_r + (AW + 1)'(1);
            end
        end
    end

    // Program counter and sticky halt flag.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            pc_r     <= '0;
            halted_r <= 1'b0;
        end else if (load_done_s) begin
            pc_r <= '0;
        end else if (halt_hit_s) begin
            halted_r <= 1'b1;
        end else if (run_step_s) begin
            if (pc_load) begin
                pc_r <= pc_in;
            end else begin
                // DEPTH is a power of two, so natural overflow wraps to 0.
                pc_r <= pc_r + AW'(1);
            end
        end
    end

    assign wr_ready   = (state_r == ST_LOAD);
    assign op         = (state_r == ST_RUN) ? op_s : '0;
    assign op_valid   = (state_r == ST_RUN) && !halted_r;
    assign pc         = pc_r;
    assign halted     = halted_r;
    assign load_count = load_count_r;

endmodule

// File: tb/tb_td4_fetch.sv
// Directed self-checking bench for td4_fetch: load/run, full load with wrap,
// halt and conditional-jump variant, step gating, loader backpressure, and
// reset in the middle of a run and of a load.
module tb_td4_fetch;

    logic       clk = 1'b0;
    logic       n_reset;
    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] wr_data;
    logic       wr_last;
    logic       step;
    logic       pc_load;
    logic [3:0] pc_in;
    logic [7:0] op;
    logic       op_valid;
    logic [3:0] pc;
    logic       halted;
    logic [4:0] load_count;

    int n_checks = 0;
    int n_errors = 0;

    td4_fetch dut (
        .clk        (clk),
        .n_reset    (n_reset),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_data    (wr_data),
        .wr_last    (wr_last),
        .step       (step),
        .pc_load    (pc_load),
        .pc_in      (pc_in),
        .op         (op),
        .op_valid   (op_valid),
        .pc         (pc),
        .halted     (halted),
        .load_count (load_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        n_reset = 1'b0;
        tick();
        n_reset = 1'b1;
    endtask

    task automatic load_word(input logic [7:0] d, input logic last);
        wr_valid = 1'b1;
        wr_data  = d;
        wr_last  = last;
        tick();
        wr_valid = 1'b0;
        wr_last  = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_wr_ready"},   16'(wr_ready),   16'd1);
        check_eq({tag, "_op_valid"},   16'(op_valid),   16'd0);
        check_eq({tag, "_op"},         16'(op),         16'd0);
        check_eq({tag, "_pc"},         16'(pc),         16'd0);
        check_eq({tag, "_halted"},     16'(halted),     16'd0);
        check_eq({tag, "_load_count"}, 16'(load_count), 16'd0);
    endtask

    // Starting at pc=0 in RUN, step once through all 16 words expecting w0 at
    // address 0 and zero everywhere else.
    task automatic check_image(input string tag, input logic [7:0] w0);
        logic [7:0] exp_op;
        step    = 1'b1;
        pc_load = 1'b0;
        for (int i = 0; i < 16; i++) begin
            exp_op = (i == 0) ? w0 : 8'h00;
            check_eq({tag, "_pc"}, 16'(pc), 16'(i));
            check_eq({tag, "_op"}, 16'(op), 16'(exp_op));
            tick();
        end
        step = 1'b0;
    endtask

    logic [7:0] prog1 [4];
    logic [3:0] exp_pc;

    initial begin
        n_reset  = 1'b0;
        wr_valid = 1'b0;
        wr_data  = 8'h00;
        wr_last  = 1'b0;
        step     = 1'b0;
        pc_load  = 1'b0;
        pc_in    = 4'h0;
        prog1[0] = 8'h31;
        prog1[1] = 8'h52;
        prog1[2] = 8'h00;
        prog1[3] = 8'hF0;

        // ---- Reset state -------------------------------------------------
        tick();
        do_reset();
        check_reset_state("rst");

        // ---- Load 4 words and run ----------------------------------------
        step = 1'b1;                      // ignored while loading
        for (int i = 0; i < 3; i++) load_word(prog1[i], 1'b0);
        check_eq("ld4_ready_before_last", 16'(wr_ready), 16'd1);
        check_eq("ld4_pc_in_load", 16'(pc), 16'd0);
        load_word(prog1[3], 1'b1);
        check_eq("ld4_ready_after_last", 16'(wr_ready), 16'd0);
        check_eq("ld4_count", 16'(load_count), 16'd4);
        check_eq("ld4_op_valid", 16'(op_valid), 16'd1);
        for (int i = 0; i < 3; i++) begin
            check_eq("run4_pc", 16'(pc), 16'(i));
            check_eq("run4_op", 16'(op), 16'(prog1[i]));
            tick();
        end
        check_eq("run4_pc3", 16'(pc), 16'd3);
        check_eq("run4_op3", 16'(op), 16'h00F0);
        pc_load = 1'b1;
        pc_in   = 4'd0;
        tick();
        pc_load = 1'b0;
        check_eq("jmp0_pc", 16'(pc), 16'd0);
        check_eq("jmp0_halted", 16'(halted), 16'd0);
        check_eq("jmp0_op", 16'(op), 16'h0031);
        step = 1'b0;

        // ---- Full load with a 5-cycle gap, then wrap ---------------------
        do_reset();
        load_word(8'h00, 1'b0);
        load_word(8'h01, 1'b0);
        wr_data = 8'hEE;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("gap_count", 16'(load_count), 16'd2);
            check_eq("gap_ready", 16'(wr_ready), 16'd1);
        end
        for (int i = 2; i < 15; i++) load_word(8'(i), 1'b0);
        check_eq("full_ready_at15", 16'(wr_ready), 16'd1);
        check_eq("full_count_at15", 16'(load_count), 16'd15);
        load_word(8'h0F, 1'b0);
        check_eq("full_ready", 16'(wr_ready), 16'd0);
        check_eq("full_count", 16'(load_count), 16'd16);
        step = 1'b1;
        for (int i = 0; i < 17; i++) begin
            check_eq("wrap_pc", 16'(pc), 16'(i % 16));
            check_eq("wrap_op", 16'(op), 16'(i % 16));
            tick();
        end

        // ---- Step gating with wr_valid asserted in RUN -------------------
        exp_pc   = 4'd1;
        wr_valid = 1'b1;
        wr_data  = 8'hAA;
        for (int i = 0; i < 8; i++) begin
            step = ((i % 2) == 0);
            tick();
            if ((i % 2) == 0) exp_pc = exp_pc + 4'd1;
            check_eq("gate_pc", 16'(pc), 16'(exp_pc));
            check_eq("gate_ready", 16'(wr_ready), 16'd0);
        end
        wr_valid = 1'b0;
        step     = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check_eq("nowr_op", 16'(op), 16'(exp_pc));
            tick();
            exp_pc = exp_pc + 4'd1;
        end
        check_eq("nowr_count", 16'(load_count), 16'd16);
        step = 1'b0;

        // ---- Halt on unconditional jump to self --------------------------
        do_reset();
        check_eq("rst2_halted", 16'(halted), 16'd0);
        load_word(8'h10, 1'b0);
        load_word(8'h20, 1'b0);
        load_word(8'hF2, 1'b1);
        step = 1'b1;
        tick();
        tick();
        check_eq("h_pc2", 16'(pc), 16'd2);
        check_eq("h_op2", 16'(op), 16'h00F2);
        step    = 1'b0;               // strobe without step must not halt
        pc_load = 1'b1;
        pc_in   = 4'd2;
        tick();
        check_eq("h_nostep_halted", 16'(halted), 16'd0);
        step = 1'b1;
        tick();
        check_eq("h_halted", 16'(halted), 16'd1);
        check_eq("h_op_valid", 16'(op_valid), 16'd0);
        check_eq("h_pc", 16'(pc), 16'd2);
        check_eq("h_op", 16'(op), 16'h00F2);
        pc_load = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i == 4) begin
                pc_load = 1'b1;
                pc_in   = 4'd7;
            end
            tick();
            check_eq("h_frozen_pc", 16'(pc), 16'd2);
            check_eq("h_sticky", 16'(halted), 16'd1);
        end
        pc_load = 1'b0;
        step    = 1'b0;

        // ---- Conditional jump to self does not halt ----------------------
        do_reset();
        check_eq("rst3_halted", 16'(halted), 16'd0);
        load_word(8'h10, 1'b0);
        load_word(8'h20, 1'b0);
        load_word(8'hE2, 1'b1);
        step = 1'b1;
        tick();
        tick();
        pc_load = 1'b1;
        pc_in   = 4'd2;
        tick();
        pc_load = 1'b0;
        check_eq("cj_halted", 16'(halted), 16'd0);
        check_eq("cj_pc", 16'(pc), 16'd2);
        check_eq("cj_op_valid", 16'(op_valid), 16'd1);
        tick();
        check_eq("cj_pc3", 16'(pc), 16'd3);
        check_eq("cj_op3", 16'(op), 16'd0);
        tick();
        tick();
        check_eq("cj_pc5", 16'(pc), 16'd5);

        // ---- Reset mid-run at pc=5 ---------------------------------------
        do_reset();
        step = 1'b0;
        check_reset_state("rrun");
        load_word(8'h77, 1'b1);
        check_eq("rrun_count", 16'(load_count), 16'd1);
        check_image("rrun_img", 8'h77);

        // ---- Reset mid-load after 2 of 4 words ---------------------------
        do_reset();
        load_word(8'h11, 1'b0);
        load_word(8'h22, 1'b0);
        check_eq("rload_count2", 16'(load_count), 16'd2);
        do_reset();
        check_reset_state("rload");
        load_word(8'h99, 1'b1);
        check_image("rload_img", 8'h99);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
